uart_word_tx: RTL and testbench
===============================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 32, meaning the input word width; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered words; it SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 Port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: in_data holds a word to send.
REQ-006 Port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 Port in_data, input, WORD_BITS bits: the word to serialise.
REQ-008 Port tx_en, output, 1 bit: a single-cycle send request to the downstream UART transmitter.
REQ-009 Port tx_data, output, 8 bits: the byte for the downstream UART transmitter.
REQ-010 Port tx_busy, input, 1 bit: the downstream UART transmitter is busy.
REQ-011 Port idle, output, 1 bit: the FIFO is empty and the FSM is in IDLE.

Function
REQ-012 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-013 in_ready SHALL be the inverse of FIFO-full, registered, and SHALL NOT depend on a same-cycle pop (no full-bypass).
REQ-014 The FIFO SHALL use read and write pointers one bit wider than log2(FIFO_DEPTH), wrapping modulo 2*FIFO_DEPTH.
  - full: pointer MSBs differ and lower bits are equal.
  - empty: pointers are equal.
REQ-015 A simultaneous push and pop SHALL each take effect, leaving the occupancy unchanged.
REQ-016 The FSM SHALL have the states IDLE, LOAD, SEND, WAIT_BUSY and WAIT_DONE.
REQ-017 IDLE SHALL go to LOAD when the FIFO is not empty and tx_busy=0; otherwise it SHALL stay in IDLE.
REQ-018 LOAD SHALL pop one word into a WORD_BITS shift register, clear the byte counter and go to SEND.
REQ-019 SEND SHALL assert tx_en for exactly one cycle, with tx_data = shift[7:0], and go to WAIT_BUSY.
REQ-020 WAIT_BUSY SHALL go to WAIT_DONE when tx_busy=1.
REQ-021 WAIT_DONE SHALL act when tx_busy=0, as follows:
  - byte counter equal to WORD_BITS/8-1: go to IDLE.
  - otherwise: shift right by 8 bits, increment the counter and go to SEND.
REQ-022 Bytes SHALL be sent LSB-first: byte 0 = in_data[7:0] and the last byte = in_data[WORD_BITS-1:WORD_BITS-8].
REQ-023 tx_data SHALL be registered and held stable from each tx_en pulse until the next one.
REQ-024 tx_en SHALL never be asserted while tx_busy=1 or while in WAIT_BUSY or WAIT_DONE.
REQ-025 With the FIFO empty and the FSM in IDLE, if a word is accepted at edge k, tx_en SHALL be high in the cycle following edge k+2.
REQ-026 Consecutive words SHALL be sent back-to-back with no lost or duplicated bytes; a new word MAY be accepted while earlier bytes are being sent.
REQ-027 The byte counter width SHALL be max(1, clog2(WORD_BITS/8)); the counter SHALL never exceed WORD_BITS/8-1.
REQ-028 idle SHALL equal 1 only when the FIFO is empty and the state is IDLE.

Reset
REQ-029 While resetn=0, the outputs SHALL be: tx_en=0, tx_data=8'h00, in_ready=0 and idle=1.
REQ-030 While resetn=0, the internal state SHALL be: state=IDLE, both pointers=0, byte counter=0 and shift register=0.
REQ-031 Reset asserted mid-word SHALL discard the buffered words and the partial word immediately (asynchronously) and SHALL emit no further tx_en.
REQ-032 in_ready SHALL rise on the first clock edge after reset is released.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (3-bit) and the constant BYTE_BITS=8.
REQ-034 The word buffer SHALL be a separate sub-module named word_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty/rdata ports.
REQ-035 The FSM, byte counter and shift register SHALL live in uart_word_tx.

Verification
REQ-036 Scenario: after reset, push 32'hA1B2C3D4 with a UART model that raises tx_busy 1 cycle after tx_en and holds it 20 cycles -> four tx_en pulses with tx_data D4, C3, B2, A1, then idle=1.
REQ-037 Scenario: push 5 words back-to-back with tx_busy held at 1 -> in_ready drops after the 4th word is accepted; the 5th word is held; after tx_busy is released, all 20 bytes are sent in order.
REQ-038 Scenario: push and pop in the same cycle at occupancy 2 -> occupancy stays 2 and the pointers wrap correctly over 10 words (byte order checked).
REQ-039 Scenario: tx_busy held at 1 before the first word -> no tx_en until tx_busy=0, then tx_en within 2 cycles.
REQ-040 Scenario: resetn pulsed low after byte 1 of 32'h11223344 -> tx_en=0 and idle=1 immediately; after release, pushing 32'h55667788 yields 88, 77, 66, 55 only.
REQ-041 Scenario: checker on all tests -> tx_en is never high for 2 consecutive cycles and never high while tx_busy=1.

Source files
------------

// File: rtl/uart_word_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx_pkg
// Description : Shared constants for the word-to-byte UART feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_word_tx_pkg;

    localparam int BYTE_BITS = 8;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_load      = 3'd1;
    localparam logic [2:0] c_st_send      = 3'd2;
    localparam logic [2:0] c_st_wait_busy = 3'd3;
    localparam logic [2:0] c_st_wait_done = 3'd4;

endpackage
`default_nettype wire

// File: rtl/uart_word_tx_word_fifo.sv
`default_nettype none
// ============================================================================
// Module      : word_fifo
// Description : Power-of-two word FIFO with extra-MSB pointers and a
//               registered full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int c_addr_bits = $clog2(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_addr_bits:0] r_wptr;
    logic [c_addr_bits:0] r_rptr;
    logic                 r_full;
    logic [c_addr_bits:0] w_wptr_next;
    logic [c_addr_bits:0] w_rptr_next;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full_next;

    assign empty = (r_wptr == r_rptr);
    assign full  = r_full;
    assign rdata = r_mem[r_rptr[c_addr_bits-1:0]];

    assign w_push      = push & ~r_full;
    assign w_pop       = pop & ~empty;
    assign w_wptr_next = r_wptr + {{c_addr_bits{1'b0}}, w_push};
    assign w_rptr_next = r_rptr + {{c_addr_bits{1'b0}}, w_pop};

    // Full is computed from the next pointers so the registered flag is never a cycle late.
    assign w_full_next = (w_wptr_next[c_addr_bits] != w_rptr_next[c_addr_bits]) &&
                         (w_wptr_next[c_addr_bits-1:0] == w_rptr_next[c_addr_bits-1:0]);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_full <= 1'b0;
        end else begin
            r_wptr <= w_wptr_next;
            r_rptr <= w_rptr_next;
            r_full <= w_full_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_addr_bits-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_tx
// Description : Buffers words and feeds them LSB-byte-first to a UART
//               transmitter using a tx_en / tx_busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx
    import uart_word_tx_pkg::*;
#(
    parameter int WORD_BITS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_BITS-1:0] in_data,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 idle
);

    localparam int c_num_bytes = WORD_BITS / BYTE_BITS;
    localparam int c_cnt_bits  = (c_num_bytes > 1) ? $clog2(c_num_bytes) : 1;
    localparam logic [c_cnt_bits-1:0] c_last_byte = c_cnt_bits'(c_num_bytes - 1);

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [WORD_BITS-1:0]  r_shift;
    logic [WORD_BITS-1:0]  w_shift_next;
    logic [c_cnt_bits-1:0] r_cnt;
    logic [7:0]            r_tx_data;
    logic                  r_ready_en;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [WORD_BITS-1:0]  w_fifo_rdata;
    logic                  w_push;
    logic                  w_pop;

    // r_ready_en keeps in_ready low during reset and lifts it on the first edge afterwards.
    assign in_ready     = r_ready_en & ~w_fifo_full;
    assign w_push       = in_valid & in_ready;
    assign w_pop        = (r_state == c_st_load);
    assign w_shift_next = r_shift >> BYTE_BITS;
    assign tx_en        = (r_state == c_st_send);
    assign tx_data      = r_tx_data;
    assign idle         = w_fifo_empty && (r_state == c_st_idle);

    word_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_push),
        .wdata  (in_data),
        .pop    (w_pop),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty),
        .rdata  (w_fifo_rdata)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:      if (!w_fifo_empty && !tx_busy) w_state_next = c_st_load;
            c_st_load:      w_state_next = c_st_send;
            c_st_send:      w_state_next = c_st_wait_busy;
            c_st_wait_busy: if (tx_busy) w_state_next = c_st_wait_done;
            c_st_wait_done: begin
                if (!tx_busy) begin
                    w_state_next = (r_cnt == c_last_byte) ? c_st_idle : c_st_send;
                end
            end
            default:        w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= c_st_idle;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tx_data  <= 8'h00;
            r_ready_en <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ready_en <= 1'b1;
            case (r_state)
                c_st_load: begin
                    r_shift   <= w_fifo_rdata;
                    r_cnt     <= '0;
                    r_tx_data <= w_fifo_rdata[BYTE_BITS-1:0];
                end
                c_st_wait_done: begin
                    // tx_data is loaded together with the move to SEND so it stays put until the next pulse.
                    if (!tx_busy && (r_cnt != c_last_byte)) begin
                        r_shift   <= w_shift_next;
                        r_cnt     <= r_cnt + c_cnt_bits'(1);
                        r_tx_data <= w_shift_next[BYTE_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_word_tx
// Description : Randomised scoreboard bench for uart_word_tx with a simple
//               busy-holding UART model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

    localparam int WB  = 32;
    localparam int FD  = 4;
    localparam int NB  = WB / 8;
    localparam int TMO = 3000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WB-1:0] in_data = '0;
    logic          tx_en;
    logic [7:0]    tx_data;
    logic          tx_busy = 1'b0;
    logic          idle;

    int         checks = 0;
    int         errors = 0;
    int         tx_count = 0;
    int         hold = 20;
    bit         force_busy = 1'b0;
    bit         prev_en = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_q[$];

    uart_word_tx #(
        .WORD_BITS  (WB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted words expand into their bytes, each tx_en pops one.
    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            exp_q.delete();
            last_data = 8'h00;
        end else begin
            if (in_valid && in_ready) begin
                for (int b = 0; b < NB; b++) begin
                    logic [WB-1:0] part;
                    part = (in_data / (WB'(1) << (8 * b))) % 256;
                    exp_q.push_back(part[7:0]);
                end
            end
            if (tx_en) begin
                tx_count++;
                check("tx_en_while_busy", {31'd0, tx_busy}, 32'd0);
                check("tx_en_two_cycles", {31'd0, prev_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%h required=none", tx_data);
                end else begin
                    check("byte_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                last_data = tx_data;
            end else begin
                check("tx_data_hold", {24'd0, tx_data}, {24'd0, last_data});
            end
        end
        prev_en = resetn ? tx_en : 1'b0;
    end

    // UART model: busy rises the cycle after tx_en and lasts 'hold' cycles.
    initial begin
        int  busy_cnt;
        bit  en;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            en = tx_en;
            @(posedge clk);
            #1;
            if (!resetn)        busy_cnt = 0;
            else if (en)        busy_cnt = hold;
            else if (busy_cnt > 0) busy_cnt--;
            tx_busy = force_busy || (busy_cnt > 0);
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Caller must be just after a rising edge.
    task automatic push_word(input logic [WB-1:0] w);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = WB'($urandom);
        check("push_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (idle && !tx_busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int  c0;
        int  seen;
        bit  got;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_en",    {31'd0, tx_en},    32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_idle",     {31'd0, idle},     32'd1);
        align();
        resetn = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("ready_after_edge",  {31'd0, in_ready}, 32'd1);

        // Single word, slow UART, latency from idle
        hold = 20;
        align();
        c0 = tx_count;
        push_word(32'hA1B2C3D4);
        repeat (2) @(negedge clk);
        check("latency_early", {31'd0, tx_en}, 32'd0);
        @(negedge clk);
        check("latency", {31'd0, tx_en}, 32'd1);
        wait_idle();
        check("word_byte_count", tx_count - c0, 32'd4);
        check("idle_after_word", {31'd0, idle}, 32'd1);

        // Fill the FIFO while the UART is busy; fifth word must wait
        force_busy = 1'b1;
        hold = 3;
        align();
        c0 = tx_count;
        for (int i = 0; i < 4; i++) push_word(WB'($urandom));
        @(negedge clk);
        check("ready_drops_full", {31'd0, in_ready}, 32'd0);
        check("queued_bytes", exp_q.size(), 32'd16);
        align();
        in_valid = 1'b1;
        in_data  = WB'($urandom);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) seen++;
        end
        check("fifth_held", seen, 32'd0);
        check("no_tx_while_forced", tx_count - c0, 32'd0);
        force_busy = 1'b0;
        align();
        push_word(in_data);
        wait_idle();
        check("five_word_bytes", tx_count - c0, 32'd20);

        // Fast UART: pushes and pops overlap, pointers wrap
        hold = 1;
        align();
        c0 = tx_count;
        for (int i = 0; i < 10; i++) push_word(WB'($urandom));
        wait_idle();
        check("stream_bytes", tx_count - c0, 32'd40);

        // Busy before the first word
        force_busy = 1'b1;
        hold = 4;
        align();
        align();
        c0 = tx_count;
        push_word(WB'($urandom));
        repeat (15) @(negedge clk);
        check("held_by_busy", tx_count - c0, 32'd0);
        force_busy = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (tx_en) got = 1'b1;
        end
        check("tx_after_busy_release", {31'd0, got}, 32'd1);
        wait_idle();

        // Reset in the middle of a word
        hold = 5;
        align();
        c0 = tx_count;
        push_word(32'h11223344);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_count == c0 + 1) begin
                got = 1'b1;
                break;
            end
        end
        check("first_byte_seen", {31'd0, got}, 32'd1);
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_tx_en",    {31'd0, tx_en},    32'd0);
        check("async_rst_idle",     {31'd0, idle},     32'd1);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("async_rst_tx_data",  {24'd0, tx_data},  32'd0);
        repeat (3) @(negedge clk);
        align();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        align();
        c0 = tx_count;
        push_word(32'h55667788);
        wait_idle();
        check("post_reset_bytes", tx_count - c0, 32'd4);

        // Random words, gaps and busy lengths
        c0 = tx_count;
        align();
        for (int i = 0; i < 20; i++) begin
            hold = int'($urandom_range(1, 8));
            repeat ($urandom_range(0, 3)) align();
            push_word(WB'($urandom));
        end
        wait_idle();
        check("random_bytes", tx_count - c0, 32'd80);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
